// File: rtl/lighting_pkg.sv
// rtl/lighting_pkg.sv - shared press kinds, encoder states and default timing for the button path
package lighting_pkg;

  typedef enum logic {
    PRESS_SHORT = 1'b0,
    PRESS_LONG  = 1'b1
  } press_kind_t;

  typedef enum logic [1:0] {
    ENC_IDLE   = 2'd0,
    ENC_BOUNCE = 2'd1,
    ENC_HOLD   = 2'd2,
    ENC_GAP    = 2'd3
  } enc_state_t;

  // Classifier and encoder both default to these so the two ends agree on timing
  localparam int DEBOUNCE_P_DEF        = 300;
  localparam int SWITCH_MODE_MIN_T_DEF = 5000;
  localparam int SHORT_HOLD_DEF        = 1000;
  localparam int LONG_HOLD_DEF         = 6000;
  localparam int GAP_T_DEF             = 16;
  localparam int CNT_W_DEF             = 16;
  localparam int BOUNCE_CYCLES         = 12;

endpackage

// File: rtl/press_timer.sv
// rtl/press_timer.sv - loadable down-counter that parks at zero
module press_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!zero) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/press_encoder.sv
// rtl/press_encoder.sv - turns one-cycle short/long commands into a push_button waveform
// Optional contact-chatter preamble enabled by PRESS_ENCODER_BOUNCE_EN.
module press_encoder
  import lighting_pkg::*;
#(
  parameter int DEBOUNCE_P        = DEBOUNCE_P_DEF,
  parameter int SWITCH_MODE_MIN_T = SWITCH_MODE_MIN_T_DEF,
  parameter int SHORT_HOLD        = SHORT_HOLD_DEF,
  parameter int LONG_HOLD         = LONG_HOLD_DEF,
  parameter int GAP_T             = GAP_T_DEF,
  parameter int CNT_W             = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic cmd_long,
  output logic cmd_ready,
  output logic push_button,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] SHORT_LOAD  = CNT_W'(SHORT_HOLD - 1);
  localparam logic [CNT_W-1:0] LONG_LOAD   = CNT_W'(LONG_HOLD - 1);
  // The IDLE cycle that carries done supplies the last low cycle of the gap
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_T - 2);
  localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
  localparam longint CNT_LIMIT = longint'(1) << CNT_W;

  if (!(SHORT_HOLD > DEBOUNCE_P + 2)) begin : g_chk_short_min
    $error("SHORT_HOLD must exceed DEBOUNCE_P+2");
  end
  if (!(SHORT_HOLD < DEBOUNCE_P + SWITCH_MODE_MIN_T)) begin : g_chk_short_max
    $error("SHORT_HOLD must be below DEBOUNCE_P+SWITCH_MODE_MIN_T");
  end
  if (!(LONG_HOLD > DEBOUNCE_P + SWITCH_MODE_MIN_T + 2)) begin : g_chk_long_min
    $error("LONG_HOLD must exceed DEBOUNCE_P+SWITCH_MODE_MIN_T+2");
  end
  if (!(GAP_T >= 2)) begin : g_chk_gap_min
    $error("GAP_T must be at least 2");
  end
  if (!(longint'(SHORT_HOLD) < CNT_LIMIT && longint'(LONG_HOLD) < CNT_LIMIT &&
        longint'(GAP_T) < CNT_LIMIT)) begin : g_chk_cnt_w
    $error("hold and gap values must fit in CNT_W bits");
  end
`ifdef PRESS_ENCODER_BOUNCE_EN
  if (!(BOUNCE_CYCLES < DEBOUNCE_P)) begin : g_chk_bounce
    $error("bounce preamble must be shorter than DEBOUNCE_P");
  end
`endif

  enc_state_t       state;
  press_kind_t      kind_in;
  logic             accept;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic [CNT_W-1:0] tmr_count;
  logic             tmr_zero;
  logic             tmr_count_unused;

  function automatic logic [CNT_W-1:0] hold_load(input press_kind_t kind);
    return (kind == PRESS_LONG) ? LONG_LOAD : SHORT_LOAD;
  endfunction

  assign kind_in          = cmd_long ? PRESS_LONG : PRESS_SHORT;
  assign cmd_ready        = (state == ENC_IDLE);
  assign busy             = (state != ENC_IDLE);
  assign accept           = cmd_valid && cmd_ready;
  assign tmr_count_unused = ^tmr_count;

`ifdef PRESS_ENCODER_BOUNCE_EN
  press_kind_t kind_q;
`endif

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ENC_IDLE: begin
        if (accept) begin
          tmr_load = 1'b1;
`ifdef PRESS_ENCODER_BOUNCE_EN
          tmr_val  = BOUNCE_LOAD;
`else
          tmr_val  = hold_load(kind_in);
`endif
        end
      end
`ifdef PRESS_ENCODER_BOUNCE_EN
      ENC_BOUNCE: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = hold_load(kind_q);
        end
      end
`endif
      ENC_HOLD: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
        end
      end
      default: ;
    endcase
  end

  press_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .count   (tmr_count),
    .zero    (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ENC_IDLE;
      push_button <= 1'b0;
      done        <= 1'b0;
`ifdef PRESS_ENCODER_BOUNCE_EN
      kind_q      <= PRESS_SHORT;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ENC_IDLE: begin
          push_button <= 1'b0;
          if (accept) begin
            push_button <= 1'b1;
`ifdef PRESS_ENCODER_BOUNCE_EN
            kind_q      <= kind_in;
            state       <= ENC_BOUNCE;
`else
            state       <= ENC_HOLD;
`endif
          end
        end
`ifdef PRESS_ENCODER_BOUNCE_EN
        ENC_BOUNCE: begin
          if (tmr_zero) begin
            state       <= ENC_HOLD;
            push_button <= 1'b1;
          end else begin
            // Level follows bit 1 of the next count: two cycles high, two low
            push_button <= ~(tmr_count[1] ^ tmr_count[0]);
          end
        end
`endif
        ENC_HOLD: begin
          push_button <= 1'b1;
          if (tmr_zero) begin
            state       <= ENC_GAP;
            push_button <= 1'b0;
          end
        end
        ENC_GAP: begin
          push_button <= 1'b0;
          if (tmr_zero) begin
            state <= ENC_IDLE;
            done  <= 1'b1;
          end
        end
        default: begin
          state       <= ENC_IDLE;
          push_button <= 1'b0;
        end
      endcase
    end
  end

endmodule
